// File: rtl/key_expander.sv
// key_expander: iterative AES-128/256 key schedule. Each round key is offered with a valid/ready handshake, and one expanded word is produced per clock.
// Optional synchronous abort input is present only when KEY_EXPANDER_ABORT_EN is defined.

module sub_byte (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // Multiplicative inverse as x^254 = prod(x^(2^k), k=1..7); 0 maps to 0.
  always_comb begin
    sq  = in_byte;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module key_expander #(
  parameter int KEY_BITS = 128,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
`ifdef KEY_EXPANDER_ABORT_EN
  input  logic                abort,
`endif
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk,
  output logic [IDX_W-1:0]    rk_idx,
  output logic                done
);
  localparam int NK    = KEY_BITS / 32;
  localparam int NR    = NK + 6;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {S_IDLE, S_OUT, S_GEN} state_t;

  state_t              state_q, state_d;
  logic [KEY_BITS-1:0] win_q, win_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          gen_q, gen_d;
  logic [127:0]        rk_q, rk_d;
  logic [IDX_W-1:0]    rk_idx_q, rk_idx_d;
  logic                rk_valid_q, rk_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic        is_rot;
  logic        is_sub;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp_x;
  logic [31:0] new_word;
  logic [7:0]  rcon_nxt;
  logic        hs;

  // Window holds the last NK words, oldest in the MSBs, so w[i-NK] is the top word and w[i-1] the bottom.
  always_comb begin
    is_rot = ((cnt_q & CNT_W'(NK - 1)) == '0);
    is_sub = (NK == 8) && (cnt_q[2:0] == 3'd4);
    sub_in = is_rot ? {win_q[23:0], win_q[31:24]} : win_q[31:0];
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sub_byte u_sub (
      .in_byte  (sub_in[8*b +: 8]),
      .out_byte (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    if (is_rot)      temp_x = sub_out ^ {rcon_q, 24'h000000};
    else if (is_sub) temp_x = sub_out;
    else             temp_x = win_q[31:0];
    new_word = win_q[KEY_BITS-1 -: 32] ^ temp_x;
    rcon_nxt = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    hs       = rk_valid_q && rk_ready;
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    rcon_d     = rcon_q;
    cnt_d      = cnt_q;
    gen_d      = gen_q;
    rk_d       = rk_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = rk_valid_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          win_d      = key_in;
          rk_d       = key_in[KEY_BITS-1 -: 128];
          rk_idx_d   = '0;
          rcon_d     = 8'h01;
          cnt_d      = CNT_W'(NK);
          gen_d      = '0;
          rk_valid_d = 1'b1;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (hs) begin
          if (rk_idx_q == IDX_W'(NR)) begin
            done_d     = 1'b1;
            rk_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else if (NK == 8 && rk_idx_q == '0) begin
            // Second half of a 256-bit key is still intact in the window.
            rk_d     = win_q[127:0];
            rk_idx_d = IDX_W'(1);
          end else begin
            rk_valid_d = 1'b0;
            gen_d      = '0;
            state_d    = S_GEN;
          end
        end
      end
      S_GEN: begin
        win_d = {win_q[KEY_BITS-33:0], new_word};
        cnt_d = cnt_q + CNT_W'(1);
        gen_d = gen_q + 2'd1;
        if (is_rot) rcon_d = rcon_nxt;
        if (gen_q == 2'd3) begin
          rk_d       = {win_q[95:0], new_word};
          rk_idx_d   = rk_idx_q + IDX_W'(1);
          rk_valid_d = 1'b1;
          state_d    = S_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef KEY_EXPANDER_ABORT_EN
    if (abort) begin
      state_d    = S_IDLE;
      rk_valid_d = 1'b0;
      done_d     = 1'b0;
      rcon_d     = 8'h01;
      cnt_d      = '0;
      gen_d      = '0;
    end
`endif
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      rcon_q     <= 8'h01;
      cnt_q      <= '0;
      gen_q      <= '0;
      rk_q       <= '0;
      rk_idx_q   <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      rcon_q     <= rcon_d;
      cnt_q      <= cnt_d;
      gen_q      <= gen_d;
      rk_q       <= rk_d;
      rk_idx_q   <= rk_idx_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk       = rk_q;
  assign rk_idx   = rk_idx_q;
  assign done     = done_q;
endmodule

// File: tb/tb_key_expander.sv
// Bench for key_expander: FIPS-197 AES-128 and AES-256 schedules, backpressure, ignored start, reset and abort.
module tb_key_expander;
  localparam int IDX_W = 4;
  localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [127:0]     rk;
  } vec_t;

  vec_t v128[11];
  vec_t v256[4];

  int total = 0;
  int bad   = 0;
  logic [IDX_W+127:0] exp_q[$];

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             start_a, busy_a, rk_valid_a, rk_ready_a, done_a;
  logic [127:0]     key_a, rk_a;
  logic [IDX_W-1:0] rk_idx_a;
  logic             start_b, busy_b, rk_valid_b, rk_ready_b, done_b;
  logic [255:0]     key_b;
  logic [127:0]     rk_b;
  logic [IDX_W-1:0] rk_idx_b;
`ifdef KEY_EXPANDER_ABORT_EN
  logic abort_a = 1'b0;
  logic abort_b = 1'b0;
`endif

  key_expander #(.KEY_BITS(128), .IDX_W(IDX_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
`ifdef KEY_EXPANDER_ABORT_EN
    .abort(abort_a),
`endif
    .key_in(key_a), .busy(busy_a), .rk_valid(rk_valid_a), .rk_ready(rk_ready_a),
    .rk(rk_a), .rk_idx(rk_idx_a), .done(done_a)
  );

  key_expander #(.KEY_BITS(256), .IDX_W(IDX_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
`ifdef KEY_EXPANDER_ABORT_EN
    .abort(abort_b),
`endif
    .key_in(key_b), .busy(busy_b), .rk_valid(rk_valid_b), .rk_ready(rk_ready_b),
    .rk(rk_b), .rk_idx(rk_idx_b), .done(done_b)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic load_exp();
    exp_q.delete();
    for (int k = 0; k < 11; k++) exp_q.push_back({v128[k].idx, v128[k].rk});
  endtask

  // Drives one AES-128 expansion; inputs change on the falling edge, outputs are scored there too.
  task automatic run_a(input int stall_at, input int junk_at, input int rst_at, input int abort_at,
                       output int done_edge, output int done_cnt, output int stalls);
    int   junk_left;
    int   stall_left;
    int   rst_wait;
    logic junk_fired;
    logic abort_pend;
    logic [IDX_W+127:0] front;
    junk_left = 0; stall_left = 7; rst_wait = -1; junk_fired = 1'b0; abort_pend = 1'b0;
    done_edge = -1; done_cnt = 0; stalls = 0;
    @(negedge clk);
    start_a = 1'b1; key_a = KEY128; rk_ready_a = 1'b1;
    for (int m = 1; m <= 150; m++) begin
      @(negedge clk);
      if (m == 1) start_a = 1'b0;
`ifdef KEY_EXPANDER_ABORT_EN
      if (abort_pend) begin
        abort_a = 1'b0;
        check("abort_valid", {127'b0, rk_valid_a}, 128'd0);
        check("abort_busy", {127'b0, busy_a}, 128'd0);
        check("abort_done", {127'b0, done_a}, 128'd0);
        return;
      end
`endif
      if (rst_wait > 0) begin
        rst_wait--;
        check("gen_valid", {127'b0, rk_valid_a}, 128'd0);
        if (rst_wait == 0) begin
          rst_n = 1'b0;
          #1;
          check("rst_busy", {127'b0, busy_a}, 128'd0);
          check("rst_valid", {127'b0, rk_valid_a}, 128'd0);
          check("rst_rk", rk_a, 128'd0);
          check("rst_idx", {124'b0, rk_idx_a}, 128'd0);
          check("rst_done", {127'b0, done_a}, 128'd0);
          return;
        end
      end
      if (done_a) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = m;
          check("busy_at_done", {127'b0, busy_a}, 128'd0);
        end
      end
      if (done_edge >= 0 && m > done_edge) break;
      rk_ready_a = 1'b1;
      if (rk_valid_a && rk_idx_a == IDX_W'(stall_at) && stall_left > 0) begin
        rk_ready_a = 1'b0;
        stall_left--;
      end
      if (junk_left > 0) begin
        junk_left--;
        if (junk_left == 0) start_a = 1'b0;
      end else if (!junk_fired && rk_valid_a && rk_idx_a == IDX_W'(junk_at)) begin
        junk_fired = 1'b1; junk_left = 3; start_a = 1'b1; key_a = ~KEY128;
      end
`ifdef KEY_EXPANDER_ABORT_EN
      if (rk_valid_a && rk_idx_a == IDX_W'(abort_at)) begin
        abort_a = 1'b1; abort_pend = 1'b1;
      end
`endif
      if (rk_valid_a && !rk_ready_a) stalls++;
      if (rk_valid_a) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_rk: got idx %0d with no key expected", rk_idx_a);
        end else begin
          front = exp_q[0];
          check("rk_idx", {124'b0, rk_idx_a}, {124'b0, front[IDX_W+127:128]});
          check("rk", rk_a, front[127:0]);
          if (rk_ready_a) begin
            void'(exp_q.pop_front());
            if (rst_at >= 0 && rk_idx_a == IDX_W'(rst_at)) rst_wait = 2;
          end
        end
      end
    end
    if (done_edge < 0) begin
      total++; bad++;
      $display("FAIL timeout_a: got no done within 150 cycles, want done");
    end
  endtask

  task automatic run_b(output int done_edge, output int hs_cnt);
    done_edge = -1; hs_cnt = 0;
    @(negedge clk);
    start_b = 1'b1; key_b = KEY256; rk_ready_b = 1'b1;
    for (int m = 1; m <= 200; m++) begin
      @(negedge clk);
      if (m == 1) start_b = 1'b0;
      if (done_b) begin
        done_edge = m;
        break;
      end
      if (rk_valid_b) begin
        check("rk256_idx", {124'b0, rk_idx_b}, 128'(hs_cnt));
        for (int t = 0; t < 4; t++)
          if (v256[t].idx == rk_idx_b) check("rk256", rk_b, v256[t].rk);
        hs_cnt++;
      end
    end
    if (done_edge < 0) begin
      total++; bad++;
      $display("FAIL timeout_b: got no done within 200 cycles, want done");
    end
  endtask

  int de, dc, st;

  initial begin
    v128[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    v128[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    v128[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    v128[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    v128[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    v128[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    v128[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    v128[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    v128[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    v128[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    v128[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    v256[0]  = '{4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
    v256[1]  = '{4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
    v256[2]  = '{4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde};
    v256[3]  = '{4'd14, 128'hfe4890d1e6188d0b046df344706c631e};

    rst_n = 1'b0;
    start_a = 1'b0; key_a = '0; rk_ready_a = 1'b0;
    start_b = 1'b0; key_b = '0; rk_ready_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {127'b0, busy_a}, 128'd0);
    check("reset_valid", {127'b0, rk_valid_a}, 128'd0);
    check("reset_rk", rk_a, 128'd0);
    check("reset_idx", {124'b0, rk_idx_a}, 128'd0);
    check("reset_done", {127'b0, done_a}, 128'd0);
    check("reset_busy_b", {127'b0, busy_b}, 128'd0);
    rst_n = 1'b1;

    // plain AES-128 with rk_ready high
    load_exp();
    run_a(-1, -1, -1, -1, de, dc, st);
    check("done_cycle", 128'(de), 128'd52);
    check("done_pulses", 128'(dc), 128'd1);
    check("keys_left", 128'(exp_q.size()), 128'd0);

    // 7-cycle backpressure at round 3
    load_exp();
    run_a(3, -1, -1, -1, de, dc, st);
    check("stall_cycles", 128'(st), 128'd7);
    check("done_cycle_stall", 128'(de), 128'd59);
    check("keys_left_stall", 128'(exp_q.size()), 128'd0);

    // start with a different key while busy
    load_exp();
    run_a(-1, 4, -1, -1, de, dc, st);
    check("done_cycle_junk", 128'(de), 128'd52);
    check("done_pulses_junk", 128'(dc), 128'd1);
    check("keys_left_junk", 128'(exp_q.size()), 128'd0);

    // asynchronous reset while generating round 6, then a clean rerun
    load_exp();
    run_a(-1, -1, 5, -1, de, dc, st);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    load_exp();
    run_a(-1, -1, -1, -1, de, dc, st);
    check("done_cycle_after_rst", 128'(de), 128'd52);
    check("keys_left_after_rst", 128'(exp_q.size()), 128'd0);

`ifdef KEY_EXPANDER_ABORT_EN
    // abort coincident with the round-5 handshake, then restart
    load_exp();
    run_a(-1, -1, -1, 5, de, dc, st);
    check("abort_no_done", 128'(de), 128'hffffffff_ffffffff_ffffffff_ffffffff);
    check("abort_keys_left", 128'(exp_q.size()), 128'd5);
    load_exp();
    run_a(-1, -1, -1, -1, de, dc, st);
    check("done_cycle_after_abort", 128'(de), 128'd52);
    check("keys_left_after_abort", 128'(exp_q.size()), 128'd0);
`endif

    // AES-256 with rk_ready high
    run_b(de, dc);
    check("done_cycle_256", 128'(de), 128'd68);
    check("handshakes_256", 128'(dc), 128'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
